fifo_level: RTL and testbench
=============================

// Module: fifo_level
// PURPOSE
//  Parametrised synchronous FIFO: successor to the fixed 8-bit fifo. First-word fall-through,
//  occupancy count and programmable almost_full/almost_empty flags. Buffers streams between
//  producer/consumer logic sharing one clock (pixel, SRAM and UART paths).
// PARAMETERS
//  DATA_WIDTH   8   bits per entry
//  ADDR_SIZE    4   log2(depth); DEPTH = 2**ADDR_SIZE (default 16 entries)
//  AF_THRESH    12  almost_full asserted when count >= AF_THRESH (1..DEPTH)
//  AE_THRESH    4   almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)
// PORTS
//  clk           in   1            rising-edge clock
//  reset         in   1            synchronous, active-low
//  write_en      in   1            push write_data this cycle
//  write_data    in   DATA_WIDTH   data to push
//  read_en       in   1            pop head entry this cycle
//  read_data     out  DATA_WIDTH   head entry; valid whenever empty==0
//  empty         out  1            count == 0
//  full          out  1            count == DEPTH
//  almost_empty  out  1            count <= AE_THRESH
//  almost_full   out  1            count >= AF_THRESH
//  count         out  ADDR_SIZE+1  entries held, 0..DEPTH
//  overflow      out  1            (FIFO_ERR_FLAGS_EN only) sticky: push dropped
//  underflow     out  1            (FIFO_ERR_FLAGS_EN only) sticky: pop on empty
// BEHAVIOUR
//  - Reset (reset==0 at posedge): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, almost_empty=1,
//    almost_full=0, overflow=underflow=0. read_data undefined (memory not cleared).
//    Reset mid-operation discards all contents; the next push after release is head.
//  - Pointers ADDR_SIZE+1 bits; low ADDR_SIZE bits index memory, MSB is wrap bit.
//    full = addr bits equal & wrap bits differ; empty = pointers equal. Wrap is natural modulo.
//  - Push accepted when write_en && (!full || read_en): mem[wr_ptr]<=write_data, wr_ptr+1.
//  - Pop accepted when read_en && !empty: rd_ptr+1.
//  - Full & both enables: pop and push both accepted, count stays DEPTH, full stays 1.
//  - Empty & both enables: push accepted, pop ignored; count becomes 1 next cycle.
//  - FWFT: read_data = mem[rd_ptr] combinationally; a word pushed at edge N is visible on
//    read_data and empty==0 after edge N (zero extra latency). Popped word is replaced after
//    the popping edge.
//  - count: +1 push only, -1 pop only, unchanged on both/neither. Registered; all flags
//    decoded from registered count/pointers (no combinational path from enables to flags).
//  - Write to full with no read: ignored, memory and pointers unchanged.
//  - Read on empty: ignored, pointers unchanged, read_data don't-care.
// CONFIGURATION
//  FIFO_ERR_FLAGS_EN defined: overflow sets on write_en && full && !read_en; underflow sets
//   on read_en && empty; both cleared only by reset.
//  Undefined: overflow/underflow ports absent; illegal ops silently ignored as above.
// STRUCTURE
//  - No shared package; DEPTH derived locally as localparam from ADDR_SIZE.
//  - One sub-module: fifo_level_mem (DEPTH x DATA_WIDTH, sync write, async read), keeps the
//    storage swappable for SB_RAM40_4K-friendly variant later.
//  - Control (pointers, count, flags, error flags) in fifo_level.
// TESTING
//  1 Reset: hold reset=0 3 cycles -> empty=1, full=0, count=0, almost_empty=1, almost_full=0.
//  2 Fill: push 0..15 (DEPTH=16) -> count 16, full=1; almost_full rises on push of value 11
//    (count 12); 17th push (value 99) dropped; pops return 0..15 in order, empty=1 after.
//  3 Interleaved: 512 cycles, push every cycle when !full, pop when !empty && i%20==0 ->
//    every popped read_data equals running expected counter; no gaps or duplicates.
//  4 Wrap: 40 push/pop pairs at count 1 -> pointers wrap twice, data 0..39 intact, count=1.
//  5 Simultaneous: at full push 0xAA + pop -> head returned, count stays 16, 0xAA is last out;
//    at empty push 0x55 + pop -> count=1, read_data=0x55.
//  6 FIFO_ERR_FLAGS_EN build: push on full -> overflow=1 sticky; pop on empty -> underflow=1;
//    both clear only after reset=0.

Source files
------------

// File: rtl/fifo_level_mem.sv
// Storage for fifo_level: DEPTH x DATA_WIDTH, synchronous write, asynchronous read.
// Kept separate so a block-RAM-friendly variant can replace it without touching control.
module fifo_level_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SIZE  = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_SIZE-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_SIZE-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  localparam int DEPTH = 2 ** ADDR_SIZE;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/fifo_level.sv
// Parametrised FWFT synchronous FIFO with occupancy count and almost flags.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module fifo_level #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SIZE  = 4,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_en,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
`ifdef FIFO_ERR_FLAGS_EN
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic [ADDR_SIZE:0]    count
);
  localparam int             PW     = ADDR_SIZE + 1;
  localparam logic [PW-1:0]  AF_LVL = PW'(AF_THRESH);
  localparam logic [PW-1:0]  AE_LVL = PW'(AE_THRESH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q,  count_d;
  logic          push, pop;

  // Flags depend only on registered state, never on the enables.
  assign empty        = (wr_ptr_q == rd_ptr_q);
  assign full         = (wr_ptr_q[ADDR_SIZE-1:0] == rd_ptr_q[ADDR_SIZE-1:0]) &&
                        (wr_ptr_q[ADDR_SIZE] != rd_ptr_q[ADDR_SIZE]);
  assign almost_empty = (count_q <= AE_LVL);
  assign almost_full  = (count_q >= AF_LVL);
  assign count        = count_q;

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push = write_en && (!full || read_en);
  assign pop  = read_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      count_d = count_q + PW'(1);
    else if (pop && !push) count_d = count_q - PW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  | (write_en && full && !read_en);
    underflow_d = underflow_q | (read_en && empty);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

  fifo_level_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_SIZE  (ADDR_SIZE)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q[ADDR_SIZE-1:0]),
    .wdata (write_data),
    .raddr (rd_ptr_q[ADDR_SIZE-1:0]),
    .rdata (read_data)
  );
endmodule

// File: tb/tb_fifo_level.sv
// Directed self-checking bench for fifo_level (DEPTH=16, AF=12, AE=4).
// Error-flag steps run only when FIFO_ERR_FLAGS_EN is defined.
module tb_fifo_level;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       write_en = 1'b0;
  logic [7:0] write_data = '0;
  logic       read_en = 1'b0;
  logic [7:0] read_data;
  logic       empty, full, almost_empty, almost_full;
  logic [4:0] count;
`ifdef FIFO_ERR_FLAGS_EN
  logic       overflow, underflow;
`endif

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  fifo_level #(
    .DATA_WIDTH (8),
    .ADDR_SIZE  (4),
    .AF_THRESH  (12),
    .AE_THRESH  (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .write_en     (write_en),
    .write_data   (write_data),
    .read_en      (read_en),
    .read_data    (read_data),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
`ifdef FIFO_ERR_FLAGS_EN
    .overflow     (overflow),
    .underflow    (underflow),
`endif
    .count        (count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of enables; returns 1ns after the edge with enables idle.
  task automatic cyc(input logic we, input logic [7:0] wd, input logic re);
    write_en   = we;
    write_data = wd;
    read_en    = re;
    @(posedge clk);
    #1;
    write_en = 1'b0;
    read_en  = 1'b0;
  endtask

  initial begin
    int wr, rd, mc;
    logic we, re;

    // 1: reset held three cycles
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
`endif

    // 2: fill, drop 17th push, drain in order
    for (int v = 0; v < 16; v++) begin
      cyc(1'b1, 8'(v), 1'b0);
      if (v == 0)  chk("fwft_first", read_data, 0);
      if (v == 3)  chk("ae_at4", almost_empty, 1);
      if (v == 4)  chk("ae_at5", almost_empty, 0);
      if (v == 10) chk("af_at11", almost_full, 0);
      if (v == 11) chk("af_at12", almost_full, 1);
    end
    chk("fill_count", count, 16);
    chk("fill_full", full, 1);
    chk("fill_empty", empty, 0);
    cyc(1'b1, 8'd99, 1'b0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("ovf_set", overflow, 1);
`endif
    chk("drop_count", count, 16);
    chk("drop_head", read_data, 0);
    for (int v = 0; v < 16; v++) begin
      chk("fill_pop", read_data, v);
      cyc(1'b0, 8'd0, 1'b1);
    end
    chk("drain_empty", empty, 1);
    chk("drain_count", count, 0);
    chk("drain_full", full, 0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("ovf_sticky", overflow, 1);
    chk("unf_clear", underflow, 0);
    cyc(1'b0, 8'd0, 1'b1);
    chk("unf_set", underflow, 1);
    chk("unf_count", count, 0);
    cyc(1'b0, 8'd0, 1'b0);
    chk("unf_sticky", underflow, 1);
`endif

    // 3: interleaved stream against a count/data model
    wr = 0; rd = 0; mc = 0;
    for (int i = 0; i < 512; i++) begin
      we = (mc != 16);
      re = (mc != 0) && (i % 20 == 0);
      if (re) begin
        chk("ilv_pop", read_data, 32'(8'(rd)));
        rd++;
      end
      cyc(we, 8'(wr), re);
      if (we) wr++;
      mc = mc + (we ? 1 : 0) - (re ? 1 : 0);
    end
    chk("ilv_count", count, mc);
    for (int k = 0; k < 16 && mc > 0; k++) begin
      chk("ilv_drain", read_data, 32'(8'(rd)));
      cyc(1'b0, 8'd0, 1'b1);
      rd++; mc--;
    end
    chk("ilv_empty", empty, 1);

    // 4: 40 push/pop pairs at occupancy 1, pointers wrap
    cyc(1'b1, 8'd0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      chk("wrap_data", read_data, i);
      cyc(1'b1, 8'(i + 1), 1'b1);
    end
    chk("wrap_count", count, 1);
    chk("wrap_last", read_data, 40);
    cyc(1'b0, 8'd0, 1'b1);
    chk("wrap_empty", empty, 1);

    // 5: simultaneous push+pop at full and at empty
    for (int v = 0; v < 16; v++) cyc(1'b1, 8'(100 + v), 1'b0);
    chk("sim_head", read_data, 100);
    cyc(1'b1, 8'hAA, 1'b1);
    chk("sim_full_count", count, 16);
    chk("sim_full", full, 1);
    for (int v = 1; v < 16; v++) begin
      chk("sim_pop", read_data, 100 + v);
      cyc(1'b0, 8'd0, 1'b1);
    end
    chk("sim_aa_last", read_data, 8'hAA);
    chk("sim_aa_count", count, 1);
    cyc(1'b0, 8'd0, 1'b1);
    chk("sim_empty", empty, 1);
    cyc(1'b1, 8'h55, 1'b1);
    chk("sim_e_count", count, 1);
    chk("sim_e_data", read_data, 8'h55);
    chk("sim_e_empty", empty, 0);

    // Reset mid-operation discards contents
    cyc(1'b1, 8'h11, 1'b0);
    cyc(1'b1, 8'h22, 1'b0);
    reset = 1'b0;
    cyc(1'b0, 8'd0, 1'b0);
    reset = 1'b1;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
`ifdef FIFO_ERR_FLAGS_EN
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_unf", underflow, 0);
`endif
    cyc(1'b1, 8'h77, 1'b0);
    chk("post_rst_head", read_data, 8'h77);
    chk("post_rst_count", count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
